aes_core_arbiter: RTL and testbench
===================================

// Module: aes_core_arbiter
// PURPOSE
// - Shares one AES-256 encrypt core among NREQ independent requesters.
// - Round-robin arbitration; sequences the core via a one-cycle start pulse; routes the result back to the winner.
// - A watchdog aborts a job if the core never signals done.
// - Sits between the crypto clients (hash/MAC/keystream units) and the AESEncrypt datapath.
// PARAMETERS
// - NREQ     4     number of requesters, 2..8
// - TIMEOUT  255   cycles allowed from core_start to core_done before abort; 8-bit counter
// PORTS
// - clk            in   1          clock
// - rst_n          in   1          asynchronous, active-low reset
// - req_valid      in   NREQ       requester i has a job
// - req_ready      out  NREQ       one-hot; job i accepted this cycle
// - req_data       in   NREQ*128   plaintext; slice i = [128*i +: 128]
// - req_key        in   NREQ*256   key; slice i = [256*i +: 256]
// - resp_valid     out  NREQ       one-hot; result for requester i held
// - resp_ready     in   NREQ       requester i consumes result
// - resp_data      out  128        ciphertext; shared bus, qualified by resp_valid
// - resp_err       out  1          result is an abort (timeout); resp_data = 0
// - core_start     out  1          one-cycle pulse: core samples core_data/core_key
// - core_data      out  128        registered plaintext to core
// - core_key       out  256        registered key to core
// - core_done      in   1          one-cycle pulse: core_result valid
// - core_result    in   128        ciphertext from core
// - busy           out  1          state != IDLE
// BEHAVIOUR
// - Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, core_start=0, core_data=0,
//   core_key=0, busy=0, rr pointer=0, FSM=IDLE. Async assert, sync deassert assumed at the top level.
// - FSM states: IDLE, ISSUE, BUSY, RESP.
// - IDLE:
//   - If any req_valid: grant the first set bit searching from ptr upward with wrap.
//   - Pulse req_ready[g]=1 for exactly that cycle; capture data/key slice g into core_data/core_key.
//   - Store g; ptr <= (g+1) mod NREQ; go to ISSUE.
// - ISSUE: core_start=1 for one cycle; clear watchdog counter; go to BUSY.
// - BUSY:
//   - On core_done: latch core_result into resp_data; resp_err=0; go to RESP.
//   - Otherwise increment the counter. When counter==TIMEOUT: resp_data=0; resp_err=1; go to RESP.
// - RESP:
//   - resp_valid[g]=1 and resp_data/resp_err stay stable until resp_ready[g].
//   - On that handshake: clear resp_valid/resp_err and return to IDLE.
// - Latency:
//   - req_valid to core_start: 2 cycles (grant, issue).
//   - core_done to resp_valid: 1 cycle.
//   - Back-to-back jobs: minimum gap of 1 IDLE cycle after the response handshake.
// - Handshake rules:
//   - A requester holds req_valid and its slices stable until req_ready.
//   - req_valid is sampled only in IDLE.
//   - resp_ready on a non-granted index is ignored.
// - Boundaries:
//   - All NREQ requesting continuously: grants rotate 0,1,..,NREQ-1,0.
//   - A single requester is granted every job, with no starvation penalty.
//   - core_done outside BUSY is ignored.
//   - core_done in the same cycle the counter reaches TIMEOUT: done wins; the result is valid.
//   - Late core_done after an abort: ignored; the core is expected to be reset by software.
//   - A requester dropping req_valid before grant: legal; it is not granted.
//   - Reset mid-operation: every state and output returns to reset values immediately.
//     In-flight job and pending response are discarded.
// STRUCTURE
// - Shared package aes_pkg:
//   - AES_BLOCK_W=128, AES_KEY_W=256.
//   - Enum arb_state_t {IDLE, ISSUE, BUSY, RESP}.
// - One sub-module rr_arbiter #(N):
//   - Inputs: req vector, ptr.
//   - Output: one-hot grant plus binary index.
//   - Purely combinational.
// - FSM, capture registers and watchdog counter live in this module.
// TESTING
// - FIPS-197 AES-256 single request (behavioral core model, 15-cycle latency):
//   - Stimulus: req 2, key 0x000102..1f, pt 0x00112233445566778899aabbccddeeff.
//   - Response: resp_valid=4'b0100, resp_data 0x8ea2b7ca516745bfeafc49904b496089, resp_err=0.
//   - Timing: core_start exactly 2 cycles after req_valid.
// - Round-robin fairness:
//   - Stimulus: req_valid=4'b1111 held for 8 jobs.
//   - Response: grant order 0,1,2,3,0,1,2,3.
//   - Then ptr=2 with req_valid=4'b0011: grant order 0,1.
// - Response backpressure:
//   - Stimulus: hold resp_ready=0 for 20 cycles.
//   - Response: resp_data stable; no new req_ready; core_start not reasserted; release -> IDLE next cycle.
// - Watchdog abort:
//   - Stimulus: core never pulses done.
//   - Response: resp_err=1 and resp_data=0 exactly TIMEOUT+1 cycles after core_start.
//   - Then a late core_done is ignored.
// - Done/timeout collision:
//   - Stimulus: core_done in the cycle counter==255.
//   - Response: resp_err=0 and resp_data=core_result.
// - Reset in BUSY:
//   - Stimulus: rst_n low in BUSY.
//   - Response: all outputs 0 in the same cycle; after release, a new request on index 3 is granted normally.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : aes_pkg                                                |
// | Brief   : Shared AES widths and arbiter state encoding.          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : aes_core_arbiter_if                                  |
// | Brief     : Requester-side job/response bus of the AES arbiter.  |
// | Rev       : 1.0  initial release                                 |
// +------------------------------------------------------------------+
interface aes_core_arbiter_if #(
    parameter int NREQ = 4
);
    import aes_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*AES_BLOCK_W-1:0] req_data;
    logic [NREQ*AES_KEY_W-1:0]   req_key;
    logic [NREQ-1:0]           resp_valid;
    logic [NREQ-1:0]           resp_ready;
    logic [AES_BLOCK_W-1:0]    resp_data;
    logic                      resp_err;

    // Crypto clients drive jobs and consume results
    modport master (
        output req_valid, req_data, req_key, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // The arbiter accepts jobs and returns results
    modport slave (
        input  req_valid, req_data, req_key, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rr_arbiter                                              |
// | Brief  : Combinational round-robin pick: first set request at or |
// |          above ptr, wrapping; one-hot grant plus binary index.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the requests starting at ptr; the first hit wins
    always_comb begin : p_search
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : aes_core_arbiter                                        |
// | Brief  : Shares one AES-256 encrypt core among NREQ requesters   |
// |          with round-robin grant, start pulse and done watchdog.  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_core_arbiter_if.slave      bus,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_data,
    output logic [AES_KEY_W-1:0]   core_key,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_result,
    output logic                   busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_BUSY  = BUSY;
    localparam logic [1:0] S_RESP  = RESP;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   core_start_q, core_start_d;
    logic [AES_BLOCK_W-1:0] core_data_q, core_data_d;
    logic [AES_KEY_W-1:0]   core_key_q, core_key_d;
    logic [NREQ-1:0]        req_ready_q, req_ready_d;
    logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
    logic [AES_BLOCK_W-1:0] resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;

    logic [NREQ-1:0]        arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Next-state logic: grant in IDLE, pulse start, watch the core, hold the result
    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        core_start_d = 1'b0;
        core_data_d  = core_data_q;
        core_key_d   = core_key_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_grant;
                    core_data_d = bus.req_data[AES_BLOCK_W*arb_idx +: AES_BLOCK_W];
                    core_key_d  = bus.req_key[AES_KEY_W*arb_idx +: AES_KEY_W];
                    gidx_d      = arb_idx;
                    ptr_d       = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start_d = 1'b1;
                cnt_d        = '0;
                state_d      = S_BUSY;
            end
            S_BUSY: begin
                // A done arriving on the last allowed cycle still counts as success
                if (core_done) begin
                    resp_data_d          = core_result;
                    resp_err_d           = 1'b0;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = S_RESP;
                end else if (cnt_q == C_TIMEOUT) begin
                    resp_data_d          = '0;
                    resp_err_d           = 1'b1;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready[gidx_q]) begin
                    resp_valid_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gidx_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            core_data_q  <= core_data_d;
            core_key_q   <= core_key_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign core_start     = core_start_q;
    assign core_data      = core_data_q;
    assign core_key       = core_key_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_aes_core_arbiter                                     |
// | Brief  : Directed, table-driven bench for aes_core_arbiter with  |
// |          a behavioral 15-cycle AES core stand-in.                |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_aes_core_arbiter;
    import aes_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] g;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_core_arbiter_if #(.NREQ(NREQ)) bus ();

    logic         core_start;
    logic [127:0] core_data;
    logic [255:0] core_key;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;

    aes_core_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int job_no  = 0;
    vec_t vecs [13];

    // Core stand-in: knows the FIPS-197 AES-256 vector, otherwise a keyed mix
    function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [255:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return (pt + key[127:0]) ^ key[255:128];
    endfunction

    logic         model_en;
    logic         model_done;
    logic [127:0] model_res;
    logic [4:0]   cd;
    logic         force_done;
    logic [127:0] force_res;

    // Behavioral core: sample on start, pulse done 15 cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd         <= '0;
            model_done <= 1'b0;
            model_res  <= '0;
        end else begin
            model_done <= 1'b0;
            if (core_start && model_en) begin
                cd        <= 5'd15;
                model_res <= model_ct(core_data, core_key);
            end else if (cd != 5'd0) begin
                cd <= cd - 5'd1;
                if (cd == 5'd1) model_done <= 1'b1;
            end
        end
    end

    assign core_done   = model_done | force_done;
    assign core_result = force_done ? force_res : model_res;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slices(input int j);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[128*i +: 128] = {4{32'hDA7A_0000 + 32'(j*16 + i)}};
            bus.req_key[256*i +: 256]  = {{4{32'hC0DE_0000 + 32'(j*16 + i)}},
                                          {4{32'h5EED_0000 + 32'(i*257)}}};
        end
    endtask

    task automatic wait_resp(input int limit, output int n);
        n = 0;
        while (bus.resp_valid == '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // One complete job: request, grant check, result check, handshake
    task automatic do_job(input logic [3:0] rv, input logic [3:0] exp_g, input string tag);
        int n;
        int gi;
        logic [3:0] g;
        logic [127:0] exp_d;
        load_slices(job_no);
        job_no++;
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (exp_g[i]) gi = i;
        exp_d = model_ct(bus.req_data[128*gi +: 128], bus.req_key[256*gi +: 256]);
        bus.req_valid = rv;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_ready == '0 && n < 5);
        g = bus.req_ready;
        bus.req_valid = '0;
        check({tag, " grant"}, g, exp_g);
        wait_resp(60, n);
        check({tag, " resp_valid"}, bus.resp_valid, exp_g);
        check({tag, " resp_data"}, bus.resp_data, exp_d);
        check({tag, " resp_err"}, bus.resp_err, 1'b0);
        bus.resp_ready = exp_g;
        tick();
        bus.resp_ready = '0;
        check({tag, " back to idle"}, {busy, bus.resp_valid}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit: actual=expired required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int bad;
        logic [127:0] held;

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_key    = '0;
        bus.resp_ready = '0;
        model_en       = 1'b1;
        force_done     = 1'b0;
        force_res      = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset ctl", {busy, core_start, bus.req_ready, bus.resp_valid, bus.resp_err}, '0);
        check("reset resp_data", bus.resp_data, '0);
        check("reset core_data", core_data, '0);
        check("reset core_key", core_key, '0);
        rst_n = 1'b1;
        tick();

        // Round-robin table: rotation, ptr=2 with 0011, single requester
        vecs[0]  = '{rv: 4'b1111, g: 4'b0001};
        vecs[1]  = '{rv: 4'b1111, g: 4'b0010};
        vecs[2]  = '{rv: 4'b1111, g: 4'b0100};
        vecs[3]  = '{rv: 4'b1111, g: 4'b1000};
        vecs[4]  = '{rv: 4'b1111, g: 4'b0001};
        vecs[5]  = '{rv: 4'b1111, g: 4'b0010};
        vecs[6]  = '{rv: 4'b1111, g: 4'b0100};
        vecs[7]  = '{rv: 4'b1111, g: 4'b1000};
        vecs[8]  = '{rv: 4'b0010, g: 4'b0010};
        vecs[9]  = '{rv: 4'b0011, g: 4'b0001};
        vecs[10] = '{rv: 4'b0011, g: 4'b0010};
        vecs[11] = '{rv: 4'b1000, g: 4'b1000};
        vecs[12] = '{rv: 4'b1000, g: 4'b1000};
        for (int v = 0; v < 13; v++) begin
            do_job(vecs[v].rv, vecs[v].g, $sformatf("rr%0d", v));
        end

        // FIPS-197 AES-256 on requester 2 with start timing
        bus.req_data[256 +: 128] = FIPS_PT;
        bus.req_key[512 +: 256]  = FIPS_KEY;
        bus.req_valid = 4'b0100;
        tick();
        check("fips grant", bus.req_ready, 4'b0100);
        check("fips start not early", core_start, 1'b0);
        bus.req_valid = '0;
        tick();
        check("fips start at +2", core_start, 1'b1);
        check("fips core_data", core_data, FIPS_PT);
        check("fips core_key", core_key, FIPS_KEY);
        wait_resp(60, n);
        check("fips resp_valid", bus.resp_valid, 4'b0100);
        check("fips resp_data", bus.resp_data, FIPS_CT);
        check("fips resp_err", bus.resp_err, 1'b0);
        bus.resp_ready = 4'b0100;
        tick();
        bus.resp_ready = '0;
        check("fips idle", {busy, bus.resp_valid}, '0);

        // Response backpressure; resp_ready on other indices must be ignored
        load_slices(job_no);
        job_no++;
        bus.req_valid = 4'b0010;
        tick();
        check("bp grant", bus.req_ready, 4'b0010);
        bus.req_valid = '0;
        wait_resp(60, n);
        check("bp resp_data", bus.resp_data, model_ct(bus.req_data[128 +: 128], bus.req_key[256 +: 256]));
        held = bus.resp_data;
        bad = 0;
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.resp_data !== held || bus.req_ready != '0 || core_start !== 1'b0 ||
                bus.resp_valid !== 4'b0010 || busy !== 1'b1) bad++;
        end
        check("bp hold violations", bad, 0);
        bus.resp_ready = 4'b0010;
        tick();
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        check("bp release idle", {busy, bus.resp_valid}, '0);
        tick();
        check("bp dropped req not granted", {busy, bus.req_ready}, '0);

        // Watchdog abort, then a late done
        model_en = 1'b0;
        load_slices(job_no);
        job_no++;
        bus.req_valid = 4'b0001;
        tick();
        check("wd grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        tick();
        check("wd start", core_start, 1'b1);
        wait_resp(400, n);
        check("wd latency", n, TIMEOUT + 1);
        check("wd resp_valid", bus.resp_valid, 4'b0001);
        check("wd resp_err", bus.resp_err, 1'b1);
        check("wd resp_data", bus.resp_data, '0);
        bus.resp_ready = 4'b0001;
        tick();
        bus.resp_ready = '0;
        force_res  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("late done ignored", {busy, bus.resp_valid, bus.resp_err}, '0);
        check("late done data", bus.resp_data, '0);

        // Done in the same cycle the counter reaches TIMEOUT
        load_slices(job_no);
        job_no++;
        bus.req_valid = 4'b0010;
        tick();
        check("col grant", bus.req_ready, 4'b0010);
        bus.req_valid = '0;
        tick();
        check("col start", core_start, 1'b1);
        repeat (TIMEOUT) tick();
        check("col no early abort", bus.resp_valid, '0);
        force_res  = 128'hC011_1DE0_0123_4567_89AB_CDEF_F00D_CAFE;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("col resp_valid", bus.resp_valid, 4'b0010);
        check("col resp_err", bus.resp_err, 1'b0);
        check("col resp_data", bus.resp_data, 128'hC011_1DE0_0123_4567_89AB_CDEF_F00D_CAFE);
        bus.resp_ready = 4'b0010;
        tick();
        bus.resp_ready = '0;

        // Reset while BUSY
        model_en = 1'b1;
        load_slices(job_no);
        job_no++;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        check("pre-reset busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst ctl", {busy, core_start, bus.req_ready, bus.resp_valid, bus.resp_err}, '0);
        check("rst resp_data", bus.resp_data, '0);
        check("rst core_data", core_data, '0);
        check("rst core_key", core_key, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_job(4'b0011, 4'b0001, "post-reset ptr");
        do_job(4'b1000, 4'b1000, "post-reset idx3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
